fifo_uart_tx: RTL and testbench

- Read-side consumer for the team's 8-bit synchronous FIFO.
- Pops one byte at a time using the FIFO's pop/empty/data_out interface.
- The FIFO's data_out is registered, so data is valid one cycle after pop.
- Serializes each byte as an asynchronous UART frame on tx: start bit, DATA_W bits LSB first, optional parity, STOP_BITS stop bits. Sits between the TX FIFO and the chip pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path and the future receiver.
//   - FSM state encoding as 3-bit localparams, plus the enum built on top of them.
//   - Line levels for the idle/stop condition and the start bit.
// No ports; import with "import uart_pkg::*;".
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_POP    = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_PARITY = 3'd5;
   localparam logic [2:0] ST_STOP   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_POP    = ST_POP,
      S_LOAD   = ST_LOAD,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } uart_state_e;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the UART TX and RX blocks.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_end marks the last cycle of a bit.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   clear    in   hold the counter at zero (restarts bit timing)
//   bit_end  out  high in the final cycle of the current bit period
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the 8-bit TX FIFO one byte at a time and serializes
// each byte as an asynchronous UART frame (start, DATA_W bits LSB first,
// optional parity, STOP_BITS stop bits) onto the tx pin.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data
// bits (even parity, or odd with PARITY_ODD=1).
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   tx_en       in   permits a new frame; looked at only while idle
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_pop
//   fifo_pop    out  one-cycle pop strobe, one per frame
//   tx          out  serial line, idle high
//   busy        out  high whenever a frame is being fetched or sent
//   tx_done     out  pulse in the last cycle of the final stop bit
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter logic        PARITY_ODD   = 1'b0
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_pop,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   // Only 1 or 2 stop bits exist, so a single bit indexes them.
   localparam logic STOP_LAST = (STOP_BITS > 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic              stop_idx_q, stop_idx_d;
   logic              tx_q, tx_d;
   logic              fifo_pop_q, fifo_pop_d;
   logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic baud_clear;
   logic bit_end;

   // Bit timing restarts at the first START cycle; the counter is parked at
   // zero while idle and during the two fetch cycles.
   assign baud_clear = (state_q == S_IDLE) || (state_q == S_POP) || (state_q == S_LOAD);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clear  (baud_clear),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (tx_en && !fifo_empty) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // fifo_data is the registered FIFO output answering last cycle's pop.
            shift_d    = fifo_data;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = (^fifo_data) ^ PARITY_ODD;
`endif
            state_d    = S_START;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (stop_idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so the pin never glitches.
      case (state_d)
         S_START: tx_d = UART_START_LEVEL;
         S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default: tx_d = UART_IDLE_LEVEL;
      endcase
      fifo_pop_d = (state_d == S_POP);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= UART_IDLE_LEVEL;
         fifo_pop_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
         fifo_pop_q <= fifo_pop_d;
         busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign fifo_pop = fifo_pop_q;
   assign busy     = busy_q;
   // Decoded purely from registers: last cycle of the final stop bit.
   assign tx_done  = (state_q == S_STOP) && bit_end && (stop_idx_q == STOP_LAST);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1.
// A behavioural FIFO feeds the DUT; bytes expected on the line are queued
// when pushed, and a separate line monitor decodes tx and compares frames.
// Define UART_TX_PARITY_EN to build and exercise the parity variant.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
   localparam int DW  = 8;
   localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int FRAME = CPB * (1 + DW + PBITS + SB);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx_en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_pop, tx, busy, tx_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int bad_pops = 0;
   logic prev_tx = 1'b1;

   logic [DW-1:0] fifo_mem[$];
   logic [DW-1:0] exp_q[$];
   int            pop_cyc[$];
   int            done_cyc[$];
   int            fall_cyc[$];
   logic          par_rx[$];

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DW),
      .STOP_BITS   (SB)
`ifdef UART_TX_PARITY_EN
      ,
      .PARITY_ODD  (1'b0)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_pop  (fifo_pop),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Registered-output FIFO: data_out and empty update on the pop edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_pop === 1'b1) begin
         if (fifo_mem.size() == 0) bad_pops <= bad_pops + 1;
         else fifo_data <= fifo_mem.pop_front();
      end
      fifo_empty <= (fifo_mem.size() == 0);
   end

   // Event recorder, sampled on the falling edge.
   always @(negedge clk) begin
      if (fifo_pop === 1'b1) pop_cyc.push_back(cyc);
      if (tx_done === 1'b1) done_cyc.push_back(cyc);
      if (prev_tx === 1'b1 && tx === 1'b0) fall_cyc.push_back(cyc);
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
      prev_tx <= tx;
   end

   // Line monitor: decodes each frame mid-bit and checks it against exp_q.
   initial begin : monitor
      logic [DW-1:0] rx_byte;
      logic [DW-1:0] exp_b;
      logic          start_b, stop_b, par_b, aborted;
      rx_byte = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && tx === 1'b0) begin
            aborted = 1'b0;
            repeat (CPB / 2) begin @(negedge clk); if (rst) aborted = 1'b1; end
            start_b = tx;
            for (int i = 0; i < DW; i++) begin
               repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
               rx_byte[i] = tx;
            end
            par_b = 1'b0;
`ifdef UART_TX_PARITY_EN
            repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
            par_b = tx;
`endif
            repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
            stop_b = tx;
            if (!aborted) begin
               check("start bit level", start_b, 0);
               check("stop bit level", stop_b, 1);
               check("frame was expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  exp_b = exp_q.pop_front();
                  check("frame data", rx_byte, exp_b);
`ifdef UART_TX_PARITY_EN
                  check("frame parity", par_b, ^exp_b);
                  par_rx.push_back(par_b);
`endif
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b, input bit expect_on_line);
      fifo_mem.push_back(b);
      if (expect_on_line) exp_q.push_back(b);
   endtask

   task automatic wait_done(input int n, input int limit, input string name);
      int k = 0;
      while (done_cyc.size() < n && k < limit) begin tick(1); k++; end
      check(name, (done_cyc.size() >= n), 1);
   endtask

   task automatic wait_fall(input int n, input int limit, input string name);
      int k = 0;
      while (fall_cyc.size() < n && k < limit) begin tick(1); k++; end
      check(name, (fall_cyc.size() >= n), 1);
   endtask

   initial begin : stimulus
      int p0, d0, f0, b0;
`ifdef UART_TX_PARITY_EN
      int r0;
`endif
      rst = 1'b1;
      tx_en = 1'b0;
      tick(3);
      check("reset tx", tx, 1);
      check("reset fifo_pop", fifo_pop, 0);
      check("reset busy", busy, 0);
      check("reset tx_done", tx_done, 0);
      rst = 1'b0;
      tick(2);

      // Empty FIFO with tx_en held: nothing happens.
      p0 = pop_cyc.size(); f0 = fall_cyc.size(); b0 = busy_cnt;
      tx_en = 1'b1;
      tick(100);
      check("empty: pops", pop_cyc.size() - p0, 0);
      check("empty: tx low", fall_cyc.size() - f0, 0);
      check("empty: busy cycles", busy_cnt - b0, 0);

      // Basic 0xA5 frame: latency and length.
      p0 = pop_cyc.size(); d0 = done_cyc.size(); f0 = fall_cyc.size(); b0 = busy_cnt;
      push(8'hA5, 1'b1);
      wait_done(d0 + 1, 200, "basic: tx_done seen");
      tick(4);
      check("basic: pops", pop_cyc.size() - p0, 1);
      check("basic: start latency", fall_cyc[f0] - pop_cyc[p0], 2);
      check("basic: tx_done cycle", done_cyc[d0] - pop_cyc[p0], FRAME + 1);
      check("basic: busy cycles", busy_cnt - b0, FRAME + 2);

      // Back-to-back 0x00, 0xFF: pops spaced by frame + IDLE/POP/LOAD.
      p0 = pop_cyc.size(); d0 = done_cyc.size(); f0 = fall_cyc.size();
      push(8'h00, 1'b1);
      push(8'hFF, 1'b1);
      wait_done(d0 + 2, 400, "b2b: both tx_done seen");
      tick(60);
      check("b2b: pops", pop_cyc.size() - p0, 2);
      check("b2b: pop spacing", pop_cyc[p0 + 1] - pop_cyc[p0], FRAME + 3);
      check("b2b: second start after done", fall_cyc[f0 + 1] - done_cyc[d0], 4);

      // tx_en dropped during bit 3 of 0x3C; a queued byte must wait.
      p0 = pop_cyc.size(); d0 = done_cyc.size(); f0 = fall_cyc.size();
      push(8'h3C, 1'b1);
      wait_fall(f0 + 1, 50, "en-drop: frame started");
      tick(CPB * 4);
      tx_en = 1'b0;
      push(8'h55, 1'b0);
      wait_done(d0 + 1, 200, "en-drop: tx_done seen");
      tick(60);
      check("en-drop: pops", pop_cyc.size() - p0, 1);
      check("en-drop: byte left in FIFO", fifo_mem.size(), 1);
      fifo_mem.delete();
      tick(3);

      // Reset in the middle of the data bits, then a clean 0x81 frame.
      tx_en = 1'b1;
      f0 = fall_cyc.size();
      push(8'h12, 1'b0);
      wait_fall(f0 + 1, 50, "rst: frame started");
      tick(CPB * 3);
      rst = 1'b1;
      #1;
      check("rst mid-frame: tx", tx, 1);
      check("rst mid-frame: busy", busy, 0);
      check("rst mid-frame: fifo_pop", fifo_pop, 0);
      tick(3);
      rst = 1'b0;
      tick(60);
      p0 = pop_cyc.size(); d0 = done_cyc.size(); f0 = fall_cyc.size();
      push(8'h81, 1'b1);
      wait_done(d0 + 1, 200, "after rst: tx_done seen");
      tick(4);
      check("after rst: pops", pop_cyc.size() - p0, 1);
      check("after rst: start latency", fall_cyc[f0] - pop_cyc[p0], 2);
      check("after rst: tx_done cycle", done_cyc[d0] - pop_cyc[p0], FRAME + 1);

`ifdef UART_TX_PARITY_EN
      // Even parity: 0xA5 has four ones -> 0, 0x07 has three ones -> 1.
      p0 = pop_cyc.size(); d0 = done_cyc.size(); r0 = par_rx.size();
      push(8'hA5, 1'b1);
      push(8'h07, 1'b1);
      wait_done(d0 + 2, 400, "parity: both tx_done seen");
      tick(4);
      check("parity: bit for 0xA5", par_rx[r0], 0);
      check("parity: bit for 0x07", par_rx[r0 + 1], 1);
      check("parity: tx_done cycle", done_cyc[d0] - pop_cyc[p0], 45);
`endif

      tick(10);
      check("all expected frames received", exp_q.size(), 0);
      check("pops while FIFO empty", bad_pops, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
